mux_scan: RTL and testbench
===========================

Name: mux_scan

Overview:
- Parametrised N-channel, W-bit registered multiplexer with valid/ready output handshake.
- Two modes: manual (external select) and scan (internal round-robin pointer stepping through channels on each accepted transfer).
- Out-of-range selects are dropped and flagged rather than producing X.
- Sits between a bank of sample sources and a single downstream consumer, replacing the combinational selector in the simulation test designs.

Parameters:
- N, 3, number of input channels (N >= 2).
- W, 1, data width per channel.
- SW, $clog2(N), select/pointer width (derived localparam, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  N*W  flattened channel data; channel k occupies bits [k*W +: W].
- sel  input  SW  channel select, used in manual mode only.
- mode  input  1  0 = manual, 1 = scan.
- in_valid  input  1  request to capture a sample this cycle.
- in_ready  output  1  block can accept a request this cycle.
- dout  output  W  registered selected data.
- out_chan  output  SW  channel index that dout came from.
- out_valid  output  1  dout/out_chan hold a valid sample.
- out_ready  input  1  downstream accepts the sample this cycle.
- err  output  1  one-cycle pulse: manual request with sel >= N was dropped.
- scan_ptr  output  SW  current scan pointer (observability).

Behaviour:
- Reset (async, rst_n = 0): dout = 0, out_chan = 0, out_valid = 0, err = 0, scan_ptr = 0. Outputs are released on the first clk edge after rst_n rises. Reset mid-transfer discards the held sample.
- in_ready = !out_valid || out_ready (combinational). A request is accepted when in_valid && in_ready.
- Active channel: ch = (mode ? scan_ptr : sel).
- Capture on an accepted request with ch < N:
  - dout <= din[ch*W +: W]; out_chan <= ch; out_valid <= 1.
  - Latency is 1 cycle from acceptance to out_valid.
- Invalid select (manual mode, accepted request, sel >= N):
  - No capture and no data change.
  - out_valid <= 0 if out_ready was high, otherwise unchanged.
  - err <= 1 for exactly one cycle.
  - Scan mode never raises err.
- Drain: out_valid && out_ready && !(accepted valid request) -> out_valid <= 0.
- Simultaneous drain and capture: the new sample replaces the old with out_valid staying 1, giving full throughput of one sample per cycle.
- Stall: out_valid && !out_ready holds dout, out_chan and out_valid stable. in_ready = 0; in_valid is ignored and sel/mode changes have no effect on the held data.
- err defaults to 0 every cycle unless the invalid-select condition occurs.
- Scan pointer:
  - Increments by 1 on each accepted request in scan mode, wrapping from N-1 to 0. Non-power-of-two N must wrap correctly (e.g. N=3: 0,1,2,0).
  - Holds when no request is accepted.
  - While mode = 0 it is forced to 0 each cycle, so entering scan mode always starts at channel 0.
- Mode change while stalled: the held sample is unaffected; the new mode applies to the next accepted request.
- din is sampled only at the capture edge; changes at other times do not affect dout.

Decomposition:
- Shared package mux_pkg: mode encodings (MODE_MANUAL = 1'b0, MODE_SCAN = 1'b1) and a function for the select width with a minimum of 1.
- Natural sub-module: scan_counter (modulo-N wrap counter with enable and synchronous clear, async active-low reset). Instantiated once for scan_ptr.
- Data path and handshake stay in the top module.

Test Plan:
- Reset: drive rst_n = 0 mid-run with out_valid = 1 -> immediately dout = 0, out_valid = 0, scan_ptr = 0, err = 0.
- Manual select (N=3, W=8, din = {8'h33, 8'h22, 8'h11}, out_ready = 1): sel = 0, 2, 1 on consecutive cycles with in_valid = 1 -> one cycle later dout = 11, 33, 22 and out_chan = 0, 2, 1, with no bubbles.
- Invalid select: sel = 3, in_valid = 1, mode = 0 -> err = 1 for one cycle; dout keeps its previous value; out_valid = 0 the following cycle.
- Scan wrap: mode = 1, in_valid = 1 for 5 cycles, out_ready = 1 -> out_chan sequence 0, 1, 2, 0, 1 with matching dout; scan_ptr = 2 at the end.
- Backpressure: out_ready = 0 for 3 cycles after a capture of 22, while din and sel change -> dout = 22 held, in_ready = 0, scan_ptr frozen. Releasing out_ready gives the next capture one cycle later.
- Mode switch: scan mode with scan_ptr = 2, then mode = 0 for 1 cycle, then mode = 1 -> scan_ptr reads 0 and the first scan capture is channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the registered scan multiplexer.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Select/pointer width for n channels, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Modulo-N wrap counter with enable and synchronous clear.
module scan_counter
  import mux_pkg::*;
#(
  parameter int unsigned N = 3,
  localparam int unsigned SW = sel_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  output logic [SW-1:0] cnt
);

  logic [SW-1:0] cnt_q, cnt_d;

  // Next count: clear wins over enable; wrap explicitly at N-1 so non-power-of-two N works.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == SW'(N - 1)) ? '0 : cnt_q + SW'(1);
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mux_scan.sv
// N-channel registered multiplexer with manual/scan select and valid/ready output.
module mux_scan
  import mux_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned W = 1,
  localparam int unsigned SW = sel_width(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] din,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   dout,
  output logic [SW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           err,
  output logic [SW-1:0]  scan_ptr
);

  logic [W-1:0]  dout_q, dout_d;
  logic [SW-1:0] chan_q, chan_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic          accept;
  logic [SW-1:0] ch;
  logic          ch_ok;
  logic [W-1:0]  sel_data;
  logic [SW-1:0] ptr;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign ch       = (mode == MODE_SCAN) ? ptr : sel;
  assign ch_ok    = (32'(ch) < N);

  // Pointer only advances on accepted scan requests and is held at 0 in manual mode.
  scan_counter #(
    .N (N)
  ) u_scan_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept && (mode == MODE_SCAN)),
    .clr   (mode == MODE_MANUAL),
    .cnt   (ptr)
  );

  // Channel data selection; out-of-range channels yield zero and are never captured.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (ch == SW'(k)) begin
        sel_data = din[k*W +: W];
      end
    end
  end

  // Capture / drop / drain decision for the output register.
  always_comb begin
    dout_d  = dout_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    if (accept && ch_ok) begin
      dout_d  = sel_data;
      chan_d  = ch;
      valid_d = 1'b1;
    end else if (accept) begin
      // Only reachable in manual mode: the scan pointer is always in range.
      err_d   = 1'b1;
      valid_d = valid_q && !out_ready;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register; async reset discards any held sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign dout      = dout_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;
  assign err       = err_q;
  assign scan_ptr  = ptr;

endmodule

// File: tb/tb_mux_scan.sv
// Randomized and directed bench for mux_scan against a behavioural model.
module tb_mux_scan;

  localparam int unsigned N  = 3;
  localparam int unsigned W  = 8;
  localparam int unsigned SW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] din;
  logic [SW-1:0]  sel;
  logic           mode;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   dout;
  logic [SW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;
  logic           err;
  logic [SW-1:0]  scan_ptr;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: what the outputs should read after the most recent clock edge.
  int m_data, m_chan, m_valid, m_err, m_ptr;

  mux_scan #(
    .N (N),
    .W (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .sel       (sel),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dout      (dout),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .scan_ptr  (scan_ptr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("dout", int'(dout), m_data);
    check("out_chan", int'(out_chan), m_chan);
    check("out_valid", int'(out_valid), m_valid);
    check("err", int'(err), m_err);
    check("scan_ptr", int'(scan_ptr), m_ptr);
  endtask

  task automatic model_reset();
    m_data = 0; m_chan = 0; m_valid = 0; m_err = 0; m_ptr = 0;
  endtask

  // Apply one cycle of stimulus and advance the model by the behavioural rules.
  task automatic drive(input int v_sel, input bit v_mode, input bit v_iv, input bit v_or,
                       input logic [N*W-1:0] v_din);
    int  ch;
    bit  rdy, acc;
    sel       = SW'(v_sel);
    mode      = v_mode;
    in_valid  = v_iv;
    out_ready = v_or;
    din       = v_din;
    #1;
    rdy = (m_valid == 0) || v_or;
    check("in_ready", int'(in_ready), int'(rdy));
    acc = v_iv && rdy;
    ch  = v_mode ? m_ptr : v_sel;
    m_err = 0;
    if (acc && ch < N) begin
      m_data  = int'(v_din[ch*W +: W]);
      m_chan  = ch;
      m_valid = 1;
    end else if (acc) begin
      m_err   = 1;
      m_valid = 0;
    end else if (m_valid == 1 && v_or) begin
      m_valid = 0;
    end
    if (!v_mode) m_ptr = 0;
    else if (acc) m_ptr = (m_ptr + 1) % N;
    @(negedge clk);
    check_outputs();
  endtask

  localparam logic [N*W-1:0] DinA = {8'h33, 8'h22, 8'h11};
  int exp_scan [5] = '{0, 1, 2, 0, 1};

  initial begin
    rst_n = 1'b0; sel = '0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Manual select back-to-back, no bubbles.
    drive(0, 0, 1, 1, DinA);
    check("man0_dout", int'(dout), 'h11);
    drive(2, 0, 1, 1, DinA);
    check("man2_dout", int'(dout), 'h33);
    check("man2_valid", int'(out_valid), 1);
    drive(1, 0, 1, 1, DinA);
    check("man1_dout", int'(dout), 'h22);
    check("man1_chan", int'(out_chan), 1);

    // Out-of-range select: dropped, flagged for one cycle.
    drive(3, 0, 1, 1, DinA);
    check("inv_err", int'(err), 1);
    check("inv_dout", int'(dout), 'h22);
    check("inv_valid", int'(out_valid), 0);
    drive(0, 0, 0, 1, DinA);
    check("inv_err_clr", int'(err), 0);

    // Scan wrap over N=3.
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 1, DinA);
      check("scan_chan", int'(out_chan), exp_scan[i]);
      check("scan_dout", int'(dout), int'(DinA[exp_scan[i]*W +: W]));
    end
    check("scan_ptr_end", int'(scan_ptr), 2);

    // Backpressure: capture 0x22, then stall with changing din/sel/mode.
    drive(1, 0, 1, 1, DinA);
    check("bp_cap", int'(dout), 'h22);
    for (int i = 0; i < 3; i++) begin
      drive(i, 1, 1, 0, N*W'($urandom));
      check("bp_hold", int'(dout), 'h22);
      check("bp_ready", int'(in_ready), 0);
      check("bp_ptr", int'(scan_ptr), 0);
    end
    drive(2, 1, 1, 1, DinA);
    check("bp_release", int'(out_chan), 0);

    // Mode switch resets the pointer; sel is ignored in scan mode.
    drive(0, 1, 1, 1, DinA);
    check("ms_ptr2", int'(scan_ptr), 2);
    drive(0, 0, 0, 1, DinA);
    check("ms_ptr0", int'(scan_ptr), 0);
    drive(3, 1, 1, 1, DinA);
    check("ms_chan", int'(out_chan), 0);
    check("ms_err", int'(err), 0);

    // Randomized traffic with occasional async reset mid-transfer.
    for (int i = 0; i < 400; i++) begin
      drive(int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0), N*W'($urandom));
      if (i % 97 == 50 && out_valid) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
